priority_bit_walker: RTL and testbench
======================================

# priority_bit_walker

Parametrised, sequential successor to the team's 8-bit combinational lowest-set-bit encoder. Captures a WIDTH-bit request vector through a valid/ready handshake. Emits the index of every set bit, one per accepted output beat, in LSB-first or MSB-first order, with a last flag and a population count. It sits between request-collection logic and any consumer that services requests one at a time, such as interrupt dispatch or channel arbitration.

## Interface
- WIDTH, 8, width of the request vector; legal range 2..64.
- POS_W, $clog2(WIDTH), width of the position output; derived, not to be overridden.
- clk  input  1  sole clock; all state updates on the rising edge.
- areset  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  a vector is offered on in_vec.
- in_ready  output  1  block accepts a vector this cycle; high only in IDLE.
- in_vec  input  WIDTH  request vector, sampled on the in_valid & in_ready edge.
- in_msb_first  input  1  scan order, sampled with in_vec: 0 = lowest index first, 1 = highest index first.
- out_valid  output  1  out_pos/out_last/out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_pos  output  POS_W  index of the current set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  the captured vector was all-zero; the single beat carries no position.
- pop_cnt  output  POS_W+1  number of set bits in the captured vector; held until the next capture.

## Operation
- State machine: IDLE and EMIT.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid=1 at the edge, load pending<=in_vec, mode<=in_msb_first and pop_cnt<=popcount(in_vec), then go to EMIT.
- EMIT: in_ready=0, out_valid=1.
  - out_pos is the lowest set index of pending when mode=0, or the highest when mode=1. It is combinational from registered state only, never from inputs.
  - out_last=1 when pending has at most one set bit.
  - out_none=1 when pending==0. In that case out_pos=0 and out_last=1.
- Beat accept (out_valid & out_ready): clear bit out_pos in pending. If out_last=1, return to IDLE.
- No accept: pending, out_pos, out_last and out_none hold stable for the whole stall, however long.
- An all-zero vector yields exactly one beat (out_none=1, pos=0, last=1) with pop_cnt=0. This matches the legacy encoder's default of 0.
- in_vec and in_msb_first are ignored outside the capture edge. Input changes during EMIT have no effect.
- pop_cnt is a register, updated only on capture.
- Reset values:
  - state=IDLE, pending=0, mode=0, pop_cnt=0.
  - Hence out_valid=0, out_pos=0, out_last=1, out_none=1 and in_ready=1.
  - Inputs are ignored while areset=1.
- Reset mid-operation: out_valid drops asynchronously as areset asserts. The remaining bits are discarded, and no beat is produced after release until a new capture.

## Timing
- Capture at edge N; first beat has out_valid=1 in the cycle after edge N.
- With out_ready held high, a vector with k set bits produces beats on k consecutive cycles. The block is back in IDLE the cycle after the last accept.
- in_ready is low from the capture edge until the edge that accepts the last beat. Minimum spacing between captures is therefore k+1 cycles (2 cycles for an all-zero vector).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- LSB-first ordering: WIDTH=8, in_vec=8'b1010_0100, msb_first=0, out_ready=1 -> beats pos 2,5,7 on three consecutive cycles; last only on 7; pop_cnt=3; in_ready returns high the cycle after pos 7.
- MSB-first ordering: same vector with msb_first=1 -> pos 7,5,2; last on 2.
- Zero vector: in_vec=0 -> exactly one beat with out_none=1, pos=0, last=1; pop_cnt=0.
- Full vector and backpressure: in_vec=8'hFF, out_ready low for 3 cycles on beat 0 and then toggling -> pos 0..7 in order with no skips or duplicates; outputs stable while stalled; pop_cnt=8.
- Mid-stream reset: in_vec=8'hF0, accept two beats (pos 4,5), then pulse areset asynchronously -> out_valid=0 immediately; after release in_ready=1 and no further beats; a new 8'h01 capture yields a single beat pos=0, last=1.
- Width scaling: WIDTH=16, in_vec=16'h8001 -> LSB-first pos 0 then 15, MSB-first pos 15 then 0; POS_W=4; pop_cnt=2.

Source files
------------

// File: rtl/priority_bit_walker.sv
// Captures a WIDTH-bit request vector and walks its set bits one per accepted beat,
// LSB-first or MSB-first, reporting a last flag, an all-zero flag and the popcount.
module priority_bit_walker #(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_last,
  output logic             out_none,
  output logic [POS_W:0]   pop_cnt
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             mode_q;
  logic [POS_W:0]   pop_d;
  logic [POS_W-1:0] lo_pos, hi_pos;
  logic             capture, accept;

  function automatic logic [POS_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [POS_W:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) sum = sum + (POS_W+1)'(v[i]);
    return sum;
  endfunction

  // Outputs depend only on registered state, so no input-to-output paths exist.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    lo_pos = '0;
    hi_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (pending_q[i]) lo_pos = POS_W'(i);
    for (int i = 0; i < WIDTH; i++)      if (pending_q[i]) hi_pos = POS_W'(i);
  end

  assign out_pos   = mode_q ? hi_pos : lo_pos;
  assign out_none  = (pending_q == '0);
  assign out_last  = ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign capture   = in_valid & in_ready;
  assign accept    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = EMIT;
      EMIT:    if (accept && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    pop_d     = pop_cnt;
    if (capture) begin
      pending_d = in_vec;
      pop_d     = popcount(in_vec);
    end else if (accept) begin
      pending_d = pending_q & ~(WIDTH'(1) << out_pos);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pending_q <= '0;
      mode_q    <= 1'b0;
      pop_cnt   <= '0;
    end else begin
      pending_q <= pending_d;
      pop_cnt   <= pop_d;
      if (capture) mode_q <= in_msb_first;
    end
  end

endmodule

// File: tb/tb_priority_bit_walker.sv
// Scoreboard bench for priority_bit_walker at WIDTH=8 and WIDTH=16: expected beats are
// queued at capture and compared as the DUT's beats are accepted.
module tb_priority_bit_walker;

  typedef struct {
    int pos;
    bit last;
    bit none;
  } beat_t;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic       in_valid8, msb8, out_ready8, in_ready8, out_valid8, last8, none8;
  logic [7:0] in_vec8;
  logic [2:0] pos8;
  logic [3:0] pop8;

  logic        in_valid16, msb16, out_ready16, in_ready16, out_valid16, last16, none16;
  logic [15:0] in_vec16;
  logic [3:0]  pos16;
  logic [4:0]  pop16;

  priority_bit_walker #(.WIDTH(8)) dut8 (
    .clk(clk), .areset(areset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_vec(in_vec8), .in_msb_first(msb8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_pos(pos8), .out_last(last8), .out_none(none8), .pop_cnt(pop8)
  );

  priority_bit_walker #(.WIDTH(16)) dut16 (
    .clk(clk), .areset(areset), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_vec(in_vec16), .in_msb_first(msb16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_pos(pos16), .out_last(last16), .out_none(none16), .pop_cnt(pop16)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t sb8[$];
  beat_t sb16[$];
  beat_t e8, e16, hold8, hold16;
  bit    stall8 = 0, stall16 = 0;
  int    lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [63:0] p, input int w, input logic m);
    int r = -1;
    for (int i = 0; i < w; i++) if (p[i] && (m || r < 0)) r = i;
    return r;
  endfunction

  task automatic push_model(input int dut, input logic [63:0] v, input int w, input logic m);
    beat_t       b;
    logic [63:0] p = v;
    int          idx;
    if (p == 0) begin
      b = '{pos: 0, last: 1'b1, none: 1'b1};
      if (dut == 0) sb8.push_back(b); else sb16.push_back(b);
    end
    while (p != 0) begin
      idx    = pick(p, w, m);
      p[idx] = 1'b0;
      b      = '{pos: idx, last: (p == 0), none: 1'b0};
      if (dut == 0) sb8.push_back(b); else sb16.push_back(b);
    end
  endtask

  // Monitors: compare accepted beats against the scoreboard and require held outputs while stalled.
  always @(negedge clk) begin
    if (areset) stall8 = 0;
    else begin
      if (stall8) begin
        check("hold_pos8", pos8, hold8.pos);
        check("hold_last8", last8, hold8.last);
        check("hold_none8", none8, hold8.none);
      end
      if (out_valid8 && out_ready8) begin
        check("beat_expected8", sb8.size() != 0, 1);
        if (sb8.size() != 0) begin
          e8 = sb8.pop_front();
          check("pos8", pos8, e8.pos);
          check("last8", last8, e8.last);
          check("none8", none8, e8.none);
        end
      end
      stall8 = out_valid8 && !out_ready8;
      hold8  = '{pos: int'(pos8), last: last8, none: none8};
    end
  end

  always @(negedge clk) begin
    if (areset) stall16 = 0;
    else begin
      if (stall16) begin
        check("hold_pos16", pos16, hold16.pos);
        check("hold_last16", last16, hold16.last);
        check("hold_none16", none16, hold16.none);
      end
      if (out_valid16 && out_ready16) begin
        check("beat_expected16", sb16.size() != 0, 1);
        if (sb16.size() != 0) begin
          e16 = sb16.pop_front();
          check("pos16", pos16, e16.pos);
          check("last16", last16, e16.last);
          check("none16", none16, e16.none);
        end
      end
      stall16 = out_valid16 && !out_ready16;
      hold16  = '{pos: int'(pos16), last: last16, none: none16};
    end
  end

  task automatic send8(input logic [7:0] v, input logic m);
    int c = 0;
    while (!in_ready8 && c < 50) begin tick(); c++; end
    check("in_ready_wait8", in_ready8, 1);
    in_valid8 = 1'b1; in_vec8 = v; msb8 = m;
    push_model(0, 64'(v), 8, m);
    tick();
    in_valid8 = 1'b0; in_vec8 = 8'($urandom); msb8 = 1'($urandom_range(0, 1));
    check("pop_cnt8", pop8, $countones(v));
  endtask

  task automatic send16(input logic [15:0] v, input logic m);
    int c = 0;
    while (!in_ready16 && c < 50) begin tick(); c++; end
    check("in_ready_wait16", in_ready16, 1);
    in_valid16 = 1'b1; in_vec16 = v; msb16 = m;
    push_model(1, 64'(v), 16, m);
    tick();
    in_valid16 = 1'b0; in_vec16 = 16'($urandom); msb16 = 1'($urandom_range(0, 1));
    check("pop_cnt16", pop16, $countones(v));
  endtask

  // mode 0: out_ready held as is, 1: random, 2: toggling every cycle.
  task automatic drain8(input int mode, output int cycles);
    cycles = 0;
    while (!in_ready8 && cycles < 100) begin
      if (mode == 1) out_ready8 = 1'($urandom_range(0, 1));
      else if (mode == 2) out_ready8 = ~out_ready8;
      tick();
      cycles++;
    end
    out_ready8 = 1'b1;
    check("drain_done8", in_ready8, 1);
    check("sb_empty8", sb8.size(), 0);
  endtask

  task automatic drain16(input int mode, output int cycles);
    cycles = 0;
    while (!in_ready16 && cycles < 100) begin
      if (mode == 1) out_ready16 = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    out_ready16 = 1'b1;
    check("drain_done16", in_ready16, 1);
    check("sb_empty16", sb16.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v16;
    logic [7:0]  v8;
    areset = 1'b1;
    in_valid8 = 0; in_vec8 = 0; msb8 = 0; out_ready8 = 1;
    in_valid16 = 0; in_vec16 = 0; msb16 = 0; out_ready16 = 1;
    repeat (2) tick();
    in_valid8 = 1'b1; in_vec8 = 8'hFF;
    tick();
    check("rst_out_valid8", out_valid8, 0);
    check("rst_in_ready8", in_ready8, 1);
    in_valid8 = 1'b0;
    #2 areset = 1'b0;
    tick();
    check("rst_pos8", pos8, 0);
    check("rst_last8", last8, 1);
    check("rst_none8", none8, 1);
    check("rst_pop8", pop8, 0);
    check("rst_out_valid16", out_valid16, 0);
    check("rst_in_ready16", in_ready16, 1);
    check("rst_pop16", pop16, 0);

    // LSB-first, MSB-first and all-zero with out_ready held high.
    send8(8'b1010_0100, 1'b0);
    check("first_beat_valid8", out_valid8, 1);
    drain8(0, lat);
    check("latency_lsb8", lat, 3);
    check("pop_held8", pop8, 3);
    send8(8'b1010_0100, 1'b1);
    drain8(0, lat);
    check("latency_msb8", lat, 3);
    send8(8'h00, 1'b0);
    drain8(0, lat);
    check("latency_zero8", lat, 1);
    check("pop_zero8", pop8, 0);

    // Full vector with a three-cycle stall on the first beat, then toggling ready.
    out_ready8 = 1'b0;
    send8(8'hFF, 1'b0);
    repeat (3) tick();
    check("stall_still_busy8", in_ready8, 0);
    drain8(2, lat);
    check("pop_full8", pop8, 8);

    // Mid-stream asynchronous reset after two accepted beats.
    send8(8'hF0, 1'b0);
    repeat (2) tick();
    check("pre_reset_pos8", pos8, 6);
    areset = 1'b1;
    #1;
    check("reset_drops_valid8", out_valid8, 0);
    check("reset_in_ready8", in_ready8, 1);
    sb8.delete();
    #2 areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_idle8", out_valid8, 0);
    end
    check("post_reset_pop8", pop8, 0);
    send8(8'h01, 1'b0);
    drain8(0, lat);
    check("latency_single8", lat, 1);

    // Random vectors, random order, random backpressure.
    for (int i = 0; i < 12; i++) begin
      v8 = 8'($urandom);
      send8(v8, 1'($urandom_range(0, 1)));
      drain8(1, lat);
    end

    // WIDTH=16 scaling.
    send16(16'h8001, 1'b0);
    drain16(0, lat);
    check("latency_lsb16", lat, 2);
    send16(16'h8001, 1'b1);
    drain16(0, lat);
    check("latency_msb16", lat, 2);
    for (int i = 0; i < 6; i++) begin
      v16 = 16'($urandom);
      send16(v16, 1'($urandom_range(0, 1)));
      drain16(1, lat);
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
